// File: rtl/flag_update_unit_pkg.sv
// Shared definitions for the NZCV flag producer: flag bit positions, op-class codes and FSM states.
package flag_update_unit_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] OPC_LOGIC = 2'b00;
   localparam logic [1:0] OPC_ARITH = 2'b01;
   localparam logic [1:0] OPC_MUL   = 2'b10;
   localparam logic [1:0] OPC_RSVD  = 2'b11;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_PEND = 1'b1
   } state_t;

endpackage

// File: rtl/flag_update_unit_nz_gen.sv
// Combinational negative/zero detection over a full-width result word.
module flag_nz_gen #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] value,
   output logic              n,
   output logic              z
);

   assign n = value[DATA_W-1];
   assign z = (value == '0);

endmodule

// File: rtl/flag_update_unit.sv
// NZCV flag producer with multi-cycle multiply tracking and MSR-style direct write.
// Build option FLAG_BYPASS_EN: flag_next_out shows the post-edge flags combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ALU updates accepted, no multiply flag update outstanding
// MUL_PEND | waiting for mul_done_in; busy asserted, ALU updates ignored
module flag_update_unit
   import flag_update_unit_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MUL_TIMEOUT = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              valid_in,
   input  logic              instr_exec_in,
   input  logic              set_flags_in,
   input  logic [1:0]        op_class_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic              alu_carry_in,
   input  logic              alu_ovf_in,
   input  logic              shift_carry_in,
   input  logic              mul_done_in,
   input  logic [DATA_W-1:0] mul_result_in,
   input  logic              msr_we_in,
   input  logic [3:0]        msr_data_in,
   output logic [3:0]        flag_register_out,
   output logic [3:0]        flag_next_out,
   output logic              flag_busy_out,
   output logic              mul_timeout_out
);

   localparam int CW = $clog2(MUL_TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_TIMEOUT - 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [3:0]      flags, flags_nxt;
   logic            timeout, timeout_nxt;
   logic            upd;
   logic            alu_n, alu_z, mul_n, mul_z;

   flag_nz_gen #(.DATA_W(DATA_W)) u_alu_nz (
      .value (alu_result_in),
      .n     (alu_n),
      .z     (alu_z)
   );

   flag_nz_gen #(.DATA_W(DATA_W)) u_mul_nz (
      .value (mul_result_in),
      .n     (mul_n),
      .z     (mul_z)
   );

   assign upd = valid_in & instr_exec_in & set_flags_in & (state == IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= IDLE;
         cnt     <= '0;
         flags   <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         flags   <= flags_nxt;
         timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (upd && op_class_in == OPC_MUL) begin
               state_nxt = MUL_PEND;
               cnt_nxt   = '0;
            end
         end
         MUL_PEND: begin
            if (mul_done_in) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Later assignments override earlier ones: mul_done N/Z > msr > ALU.
   always_comb begin
      flags_nxt = flags;
      if (upd) begin
         case (op_class_in)
            OPC_LOGIC: begin
               flags_nxt[FLAG_N] = alu_n;
               flags_nxt[FLAG_Z] = alu_z;
               flags_nxt[FLAG_C] = shift_carry_in;
            end
            OPC_ARITH: begin
               flags_nxt[FLAG_N] = alu_n;
               flags_nxt[FLAG_Z] = alu_z;
               flags_nxt[FLAG_C] = alu_carry_in;
               flags_nxt[FLAG_V] = alu_ovf_in;
            end
            default: ;
         endcase
      end
      if (msr_we_in) begin
         flags_nxt = msr_data_in;
      end
      if (state == MUL_PEND && mul_done_in) begin
         flags_nxt[FLAG_N] = mul_n;
         flags_nxt[FLAG_Z] = mul_z;
      end
   end

   assign flag_register_out = flags;
   assign flag_busy_out     = (state == MUL_PEND);
   assign mul_timeout_out   = timeout;

`ifdef FLAG_BYPASS_EN
   assign flag_next_out = rst_in ? 4'b0000 : flags_nxt;
`else
   assign flag_next_out = flags;
`endif

endmodule
